// File: rtl/calc_pkg.sv
// calc_pkg: shared encodings for the multi-cycle execute stage.
//   alu_op_e     - ALU operation codes (12-15 reserved, produce 0)
//   alu_src_a_e  - ALUSrcA mux selects
//   alu_src_b_e  - ALUSrcB mux selects
//   mul_state_e  - multiply sequencer states
package calc_pkg;

  typedef enum logic [3:0] {
    OP_ADD   = 4'd0,
    OP_SUB   = 4'd1,
    OP_AND   = 4'd2,
    OP_OR    = 4'd3,
    OP_XOR   = 4'd4,
    OP_NOR   = 4'd5,
    OP_SLL   = 4'd6,
    OP_SRL   = 4'd7,
    OP_SRA   = 4'd8,
    OP_SLT   = 4'd9,
    OP_PASSB = 4'd10,
    OP_MUL   = 4'd11
  } alu_op_e;

  typedef enum logic [1:0] {
    SRC_A_PC  = 2'd0,
    SRC_A_ONE = 2'd1,
    SRC_A_REG = 2'd2,
    SRC_A_IMM = 2'd3
  } alu_src_a_e;

  typedef enum logic [1:0] {
    SRC_B_REG  = 2'd0,
    SRC_B_ONE  = 2'd1,
    SRC_B_IMM  = 2'd2,
    SRC_B_ZERO = 2'd3
  } alu_src_b_e;

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StMul  = 2'd1,
    StDone = 2'd2
  } mul_state_e;

endpackage

// File: rtl/calc_alu.sv
// calc_alu: purely combinational ALU.
//   i_op_a, i_op_b : operands (WIDTH)
//   i_op           : operation code (alu_op_e encoding, reserved codes give 0)
//   o_result       : result (WIDTH), modulo 2^WIDTH
//   o_zero         : result == 0
//   o_negative     : result MSB
//   o_carry        : ADD carry-out, SUB no-borrow (a >= b unsigned), else 0
module calc_alu
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH = 16
) (
  input  logic [WIDTH-1:0] i_op_a,
  input  logic [WIDTH-1:0] i_op_b,
  input  logic [3:0]       i_op,
  output logic [WIDTH-1:0] o_result,
  output logic             o_zero,
  output logic             o_negative,
  output logic             o_carry
);

  localparam int unsigned ShW = $clog2(WIDTH);

  logic [ShW-1:0] w_shamt;
  logic [WIDTH:0] w_sum;

  assign w_shamt = i_op_b[ShW-1:0];
  assign w_sum   = {1'b0, i_op_a} + {1'b0, i_op_b};

  always_comb begin
    o_result = '0;
    o_carry  = 1'b0;
    case (alu_op_e'(i_op))
      OP_ADD: begin
        o_result = w_sum[WIDTH-1:0];
        o_carry  = w_sum[WIDTH];
      end
      OP_SUB: begin
        o_result = i_op_a - i_op_b;
        o_carry  = (i_op_a >= i_op_b);
      end
      OP_AND:   o_result = i_op_a & i_op_b;
      OP_OR:    o_result = i_op_a | i_op_b;
      OP_XOR:   o_result = i_op_a ^ i_op_b;
      OP_NOR:   o_result = ~(i_op_a | i_op_b);
      OP_SLL:   o_result = i_op_a << w_shamt;
      OP_SRL:   o_result = i_op_a >> w_shamt;
      OP_SRA:   o_result = $unsigned($signed(i_op_a) >>> w_shamt);
      OP_SLT:   o_result = {{(WIDTH-1){1'b0}}, ($signed(i_op_a) < $signed(i_op_b))};
      OP_PASSB: o_result = i_op_b;
      // Product is produced by the sequencer in the top, never combinationally.
      default:  o_result = '0;
    endcase
  end

  assign o_zero     = (o_result == '0);
  assign o_negative = o_result[WIDTH-1];

endmodule

// File: rtl/calc_datapath_mc.sv
// calc_datapath_mc: execute stage of the multi-cycle processor.
//   A/B operand registers, ALUSrcA/B muxes, ALU, ALUOut register, PCSrc mux,
//   write-enabled flag registers and an iterative shift-add multiplier.
// Ports:
//   i_clk, i_reset          : clock, synchronous active-high reset
//   i_a, i_b                : register-file read data (captured while idle)
//   i_pc, i_imm             : current PC, sign-extended immediate
//   i_alu_src_a/b           : operand mux selects (alu_src_a_e / alu_src_b_e)
//   i_alu_op                : operation (alu_op_e)
//   i_pc_src                : 0 -> o_mux_out = o_alu_result, 1 -> o_alu_out_q
//   i_flag_we               : load flags from the ALU this cycle (idle only)
//   i_start                 : launches a multiply when i_alu_op == OP_MUL
//   o_busy, o_done          : multiply in progress / one-cycle completion pulse
//   o_alu_result            : combinational ALU result
//   o_alu_out_q, o_b_q      : ALUOut and B registers
//   o_mux_out               : PCSrc mux output
//   o_zero/negative/carry   : registered flags
module calc_datapath_mc
  import calc_pkg::*;
#(
  parameter int unsigned WIDTH   = 16,
  // Must equal WIDTH: one multiplier bit is consumed per iteration.
  parameter int unsigned MUL_LAT = WIDTH
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic [WIDTH-1:0] i_a,
  input  logic [WIDTH-1:0] i_b,
  input  logic [WIDTH-1:0] i_pc,
  input  logic [WIDTH-1:0] i_imm,
  input  logic [1:0]       i_alu_src_a,
  input  logic [1:0]       i_alu_src_b,
  input  logic [3:0]       i_alu_op,
  input  logic             i_pc_src,
  input  logic             i_flag_we,
  input  logic             i_start,
  output logic             o_busy,
  output logic             o_done,
  output logic [WIDTH-1:0] o_alu_result,
  output logic [WIDTH-1:0] o_alu_out_q,
  output logic [WIDTH-1:0] o_mux_out,
  output logic [WIDTH-1:0] o_b_q,
  output logic             o_zero,
  output logic             o_negative,
  output logic             o_carry
);

  localparam int unsigned CntW = $clog2(MUL_LAT + 1);
  localparam logic [WIDTH-1:0] One = WIDTH'(1);

  mul_state_e       r_state, w_state_next;
  logic [WIDTH-1:0] r_a, r_b, r_alu_out;
  logic             r_zero, r_negative, r_carry;
  logic [WIDTH-1:0] r_mcand, r_mplier, r_acc;
  logic [CntW-1:0]  r_cnt;

  logic [WIDTH-1:0] w_op_a, w_op_b, w_alu_result;
  logic             w_alu_zero, w_alu_negative, w_alu_carry;
  logic             w_mul_start, w_mul_last;

  // Operand muxes
  always_comb begin
    w_op_a = '0;
    case (alu_src_a_e'(i_alu_src_a))
      SRC_A_PC:  w_op_a = i_pc;
      SRC_A_ONE: w_op_a = One;
      SRC_A_REG: w_op_a = r_a;
      SRC_A_IMM: w_op_a = i_imm;
      default:   w_op_a = '0;
    endcase
  end

  always_comb begin
    w_op_b = '0;
    case (alu_src_b_e'(i_alu_src_b))
      SRC_B_REG:  w_op_b = r_b;
      SRC_B_ONE:  w_op_b = One;
      SRC_B_IMM:  w_op_b = i_imm;
      SRC_B_ZERO: w_op_b = '0;
      default:    w_op_b = '0;
    endcase
  end

  calc_alu #(
    .WIDTH(WIDTH)
  ) u_alu (
    .i_op_a    (w_op_a),
    .i_op_b    (w_op_b),
    .i_op      (i_alu_op),
    .o_result  (w_alu_result),
    .o_zero    (w_alu_zero),
    .o_negative(w_alu_negative),
    .o_carry   (w_alu_carry)
  );

  assign w_mul_start = (r_state == StIdle) && i_start && (i_alu_op == OP_MUL);
  assign w_mul_last  = (r_cnt == CntW'(MUL_LAT - 1));

  // Multiply sequencer: state register
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Multiply sequencer: next state and handshake outputs
  always_comb begin
    w_state_next = r_state;
    o_busy       = 1'b0;
    o_done       = 1'b0;
    unique case (r_state)
      StIdle: begin
        if (w_mul_start) w_state_next = StMul;
      end
      StMul: begin
        o_busy = 1'b1;
        if (w_mul_last) w_state_next = StDone;
      end
      StDone: begin
        o_done       = 1'b1;
        w_state_next = StIdle;
      end
      default: w_state_next = StIdle;
    endcase
  end

  // Operand, ALUOut, flag and multiplier registers
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_a        <= '0;
      r_b        <= '0;
      r_alu_out  <= '0;
      r_zero     <= 1'b0;
      r_negative <= 1'b0;
      r_carry    <= 1'b0;
      r_mcand    <= '0;
      r_mplier   <= '0;
      r_acc      <= '0;
      r_cnt      <= '0;
    end else begin
      unique case (r_state)
        StIdle: begin
          r_a       <= i_a;
          r_b       <= i_b;
          r_alu_out <= w_alu_result;
          if (i_flag_we) begin
            r_zero     <= w_alu_zero;
            r_negative <= w_alu_negative;
            r_carry    <= w_alu_carry;
          end
          if (w_mul_start) begin
            r_mcand  <= w_op_a;
            r_mplier <= w_op_b;
            r_acc    <= '0;
            r_cnt    <= '0;
          end
        end
        StMul: begin
          // Only the low WIDTH bits of the product are kept, so mcand may shift out.
          r_acc    <= r_acc + (r_mplier[0] ? r_mcand : '0);
          r_mcand  <= r_mcand << 1;
          r_mplier <= r_mplier >> 1;
          r_cnt    <= r_cnt + CntW'(1);
        end
        StDone: begin
          r_alu_out  <= r_acc;
          r_zero     <= (r_acc == '0);
          r_negative <= r_acc[WIDTH-1];
          r_carry    <= 1'b0;
        end
        default: ;
      endcase
    end
  end

  assign o_alu_result = w_alu_result;
  assign o_alu_out_q  = r_alu_out;
  assign o_mux_out    = i_pc_src ? r_alu_out : w_alu_result;
  assign o_b_q        = r_b;
  assign o_zero       = r_zero;
  assign o_negative   = r_negative;
  assign o_carry      = r_carry;

endmodule

// File: tb/tb_calc_datapath_mc.sv
// Self-checking bench for calc_datapath_mc (WIDTH = 16): a behavioural model checked every
// cycle, plus directed vectors with hand-computed literal expectations.
module tb_calc_datapath_mc;

  localparam int Lat = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] a_in, b_in, pc_in, imm_in;
  logic [1:0]  src_a, src_b;
  logic [3:0]  alu_op;
  logic        pc_src, flag_we, start;
  logic        busy, done, zero, negative, carry;
  logic [15:0] alu_result, alu_out_q, mux_out, b_q;

  always #5 clk = ~clk;

  calc_datapath_mc #(
    .WIDTH  (16),
    .MUL_LAT(16)
  ) dut (
    .i_clk       (clk),
    .i_reset     (reset),
    .i_a         (a_in),
    .i_b         (b_in),
    .i_pc        (pc_in),
    .i_imm       (imm_in),
    .i_alu_src_a (src_a),
    .i_alu_src_b (src_b),
    .i_alu_op    (alu_op),
    .i_pc_src    (pc_src),
    .i_flag_we   (flag_we),
    .i_start     (start),
    .o_busy      (busy),
    .o_done      (done),
    .o_alu_result(alu_result),
    .o_alu_out_q (alu_out_q),
    .o_mux_out   (mux_out),
    .o_b_q       (b_q),
    .o_zero      (zero),
    .o_negative  (negative),
    .o_carry     (carry)
  );

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=%0h required=%0h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Reference ALU: returns {carry, result}
  function automatic logic [16:0] f_alu(input logic [3:0] op, input logic [15:0] x,
                                        input logic [15:0] y);
    logic [3:0] sh;
    sh = y[3:0];
    case (op)
      4'd0:    return {1'b0, x} + {1'b0, y};
      4'd1:    return {(x >= y), 16'(x - y)};
      4'd2:    return {1'b0, x & y};
      4'd3:    return {1'b0, x | y};
      4'd4:    return {1'b0, x ^ y};
      4'd5:    return {1'b0, ~(x | y)};
      4'd6:    return {1'b0, 16'(x << sh)};
      4'd7:    return {1'b0, 16'(x >> sh)};
      4'd8:    return {1'b0, 16'($unsigned($signed(x) >>> sh))};
      4'd9:    return {16'd0, ($signed(x) < $signed(y))};
      4'd10:   return {1'b0, y};
      default: return 17'd0;
    endcase
  endfunction

  // Model state: m_phase 0 = idle, 1..Lat = multiplying, Lat+1 = done cycle
  logic [15:0] m_a = '0, m_b = '0, m_out = '0, m_prod = '0;
  logic        m_z = 1'b0, m_n = 1'b0, m_c = 1'b0;
  int          m_phase = 0;
  logic [15:0] m_opa, m_opb;
  logic [16:0] m_res;

  always_comb begin
    m_opa = '0;
    case (src_a)
      2'd0: m_opa = pc_in;
      2'd1: m_opa = 16'd1;
      2'd2: m_opa = m_a;
      default: m_opa = imm_in;
    endcase
    m_opb = '0;
    case (src_b)
      2'd0: m_opb = m_b;
      2'd1: m_opb = 16'd1;
      2'd2: m_opb = imm_in;
      default: m_opb = 16'd0;
    endcase
  end

  assign m_res = f_alu(alu_op, m_opa, m_opb);

  always @(posedge clk) begin
    if (reset) begin
      m_a <= '0; m_b <= '0; m_out <= '0; m_prod <= '0;
      m_z <= 1'b0; m_n <= 1'b0; m_c <= 1'b0; m_phase <= 0;
    end else if (m_phase == 0) begin
      m_a   <= a_in;
      m_b   <= b_in;
      m_out <= m_res[15:0];
      if (flag_we) begin
        m_z <= (m_res[15:0] == 16'd0);
        m_n <= m_res[15];
        m_c <= m_res[16];
      end
      if (start && alu_op == 4'd11) begin
        m_phase <= 1;
        m_prod  <= m_opa * m_opb;
      end
    end else if (m_phase <= Lat) begin
      m_phase <= m_phase + 1;
    end else begin
      m_out   <= m_prod;
      m_z     <= (m_prod == 16'd0);
      m_n     <= m_prod[15];
      m_c     <= 1'b0;
      m_phase <= 0;
    end
  end

  // Cycle-by-cycle compare against the model
  always @(negedge clk) begin
    if (chk_en) begin
      chk("alu_result", alu_result, m_res[15:0]);
      chk("alu_out_q", alu_out_q, m_out);
      chk("mux_out", mux_out, pc_src ? m_out : m_res[15:0]);
      chk("b_q", b_q, m_b);
      chk("zero", zero, m_z);
      chk("negative", negative, m_n);
      chk("carry", carry, m_c);
      chk("busy", busy, (m_phase >= 1 && m_phase <= Lat));
      chk("done", done, (m_phase == Lat + 1));
    end
  end

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_op(input logic [1:0] sa, input logic [1:0] sb, input logic [3:0] op,
                        input logic [15:0] av, input logic [15:0] bv);
    src_a  = sa;
    src_b  = sb;
    alu_op = op;
    a_in   = av;
    b_in   = bv;
  endtask

  int n_done;

  initial begin
    reset   = 1'b1;
    a_in    = 16'hFFFF; b_in = 16'hFFFF; pc_in = 16'hFFFF; imm_in = 16'hFFFF;
    src_a   = 2'b11;    src_b = 2'b11;   alu_op = 4'hF;
    pc_src  = 1'b1;     flag_we = 1'b1;  start = 1'b1;

    // Reset with every input high
    cycles(1);
    chk_en = 1'b1;
    chk("rst alu_out_q", alu_out_q, 16'h0000);
    chk("rst flags", {zero, negative, carry}, 3'b000);
    chk("rst busy", busy, 1'b0);
    chk("rst done", done, 1'b0);

    reset = 1'b0; start = 1'b0; pc_src = 1'b0; pc_in = 16'h0000; imm_in = 16'h0000;

    // ADD wrap-around with carry
    set_op(2'd2, 2'd0, 4'd0, 16'hFFFF, 16'h0001);
    cycles(2);
    chk("add out", alu_out_q, 16'h0000);
    chk("add zcn", {zero, carry, negative}, 3'b110);

    // SUB with borrow
    set_op(2'd2, 2'd0, 4'd1, 16'h0003, 16'h0005);
    cycles(2);
    chk("sub out", alu_out_q, 16'hFFFE);
    chk("sub zcn", {zero, carry, negative}, 3'b001);

    // SLT signed
    set_op(2'd2, 2'd0, 4'd9, 16'h8000, 16'h0001);
    cycles(2);
    chk("slt out", alu_out_q, 16'h0001);

    // SRA by 4 from immediate
    set_op(2'd2, 2'd2, 4'd8, 16'h8000, 16'h0000);
    imm_in = 16'h0004;
    cycles(2);
    chk("sra out", alu_out_q, 16'hF800);

    // XOR
    set_op(2'd2, 2'd0, 4'd4, 16'h0F0F, 16'h00FF);
    cycles(2);
    chk("xor out", alu_out_q, 16'h0FF0);

    // Reserved op gives zero
    set_op(2'd2, 2'd0, 4'd13, 16'h1234, 16'h5678);
    cycles(2);
    chk("rsvd out", alu_out_q, 16'h0000);
    chk("rsvd zero", zero, 1'b1);

    // PC + 1 through the combinational path
    set_op(2'd0, 2'd1, 4'd0, 16'h0000, 16'h0000);
    pc_in = 16'h0100;
    cycles(1);
    chk("pc+1 mux", mux_out, 16'h0101);

    // Multiply 0x0123 * 0x0045, with stray start/flag_we while busy
    flag_we = 1'b0;
    set_op(2'd2, 2'd0, 4'd11, 16'h0123, 16'h0045);
    cycles(1);
    start = 1'b1;
    cycles(1);                               // cycle T+1
    chk("mul busy T+1", busy, 1'b1);
    flag_we = 1'b1; alu_op = 4'd0; a_in = 16'h7777;
    cycles(15);                              // cycle T+16
    chk("mul busy T+16", busy, 1'b1);
    chk("mul done T+16", done, 1'b0);
    cycles(1);                               // cycle T+17
    chk("mul done T+17", done, 1'b1);
    chk("mul busy T+17", busy, 1'b0);
    start = 1'b0; flag_we = 1'b0;
    cycles(1);                               // cycle T+18
    chk("mul product", alu_out_q, 16'h4E6F);
    chk("mul zcn", {zero, carry, negative}, 3'b000);
    chk("mul done T+18", done, 1'b0);

    // Reset in the middle of a multiply
    set_op(2'd2, 2'd0, 4'd11, 16'h0123, 16'h0045);
    cycles(1);
    start = 1'b1;
    cycles(1);                               // cycle T+1
    start = 1'b0;
    cycles(7);                               // cycle T+8
    chk("abort busy before", busy, 1'b1);
    reset = 1'b1; pc_src = 1'b1;
    cycles(1);
    chk("abort busy", busy, 1'b0);
    chk("abort done", done, 1'b0);
    chk("abort alu_out_q", alu_out_q, 16'h0000);
    chk("abort mux_out", mux_out, 16'h0000);
    reset = 1'b0;
    set_op(2'd2, 2'd2, 4'd0, 16'h1234, 16'h0000);
    imm_in = 16'h0011;
    cycles(2);
    chk("pcsrc mux_out", mux_out, 16'h1245);
    n_done = 0;
    for (int i = 0; i < 18; i++) begin
      cycles(1);
      if (done) n_done++;
    end
    chk("abort no done", n_done, 0);

    @(negedge clk);
    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
